// File: rtl/control_pkg.sv
// Shared definitions for the MIPS control-unit microprogram sequencer:
// state width, reset/fetch defaults, next-state mode and condition-select codes.
package control_pkg;

    localparam int STATE_W     = 7;
    localparam int RESET_STATE = 0;
    localparam int FETCH_STATE = 1;
    localparam int WAIT_LIMIT  = 255;
    localparam int WAIT_CNT_W  = 8;

    // Next-state mode field (N) carried by every control-ROM word.
    typedef enum logic [2:0] {
        MODE_DECODE   = 3'b000,
        MODE_FETCH    = 3'b001,
        MODE_INC      = 3'b010,
        MODE_JUMP     = 3'b011,
        MODE_BR_INC   = 3'b100,
        MODE_BR_DEC   = 3'b101,
        MODE_WAIT     = 3'b110,
        MODE_BR_FETCH = 3'b111
    } mode_e;

    // Condition select field (S).
    typedef enum logic [1:0] {
        CSEL_MOC  = 2'b00,
        CSEL_COND = 2'b01,
        CSEL_ZERO = 2'b10,
        CSEL_ONE  = 2'b11
    } csel_e;

endpackage

// File: rtl/seq_cond_select.sv
// Branch/wait condition for the sequencer: picks MOC, Cond, Zero or a
// constant 1 by S and optionally inverts it. Purely combinational.
module seq_cond_select
    import control_pkg::*;
(
    input  logic [1:0] S,
    input  logic       Inv,
    input  logic       MOC,
    input  logic       Cond,
    input  logic       Zero,
    output logic       C
);

    logic sel;

    // Select the raw condition, then apply the ROM's invert bit.
    always_comb begin
        // NOTE: default every always_comb output before the case so no path leaves it unassigned (which would infer a latch).
        sel = 1'b1;
        case (csel_e'(S))
            CSEL_MOC:  sel = MOC;
            CSEL_COND: sel = Cond;
            CSEL_ZERO: sel = Zero;
            CSEL_ONE:  sel = 1'b1;
        endcase
        C = sel ^ Inv;
    end

endmodule

// File: rtl/control_state_sequencer.sv
// Microprogram next-state sequencer for the MIPS control unit. Holds the
// control state (the control-ROM address) and picks the next state from the
// ROM's N/Inv/S/CR fields and the instruction encoder's State_Sel.
// Optional build macro SEQ_WAIT_TIMEOUT_EN adds a WAIT-mode cycle limit that
// forces a return to fetch and sets a sticky Timeout flag.
module control_state_sequencer #(
    parameter int STATE_W     = control_pkg::STATE_W,
    parameter int RESET_STATE = control_pkg::RESET_STATE,
    parameter int FETCH_STATE = control_pkg::FETCH_STATE,
    parameter int WAIT_LIMIT  = control_pkg::WAIT_LIMIT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic [2:0]         N,
    input  logic               Inv,
    input  logic [1:0]         S,
    input  logic [STATE_W-1:0] CR,
    input  logic               MOC,
    input  logic               Cond,
    input  logic               Zero,
    output logic [STATE_W-1:0] State,
    output logic [STATE_W-1:0] Next_State,
    output logic               Decoded,
    output logic               Timeout
);
    import control_pkg::*;

    localparam logic [STATE_W-1:0] RESET_VAL = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_VAL = STATE_W'(FETCH_STATE);

    logic               c;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] next_state;
    logic               use_sel;
    mode_e              mode;

    seq_cond_select u_cond (
        .S    (S),
        .Inv  (Inv),
        .MOC  (MOC),
        .Cond (Cond),
        .Zero (Zero),
        .C    (c)
    );

    assign mode = mode_e'(N);
    assign inc  = State + STATE_W'(1);  // wraps modulo 2^STATE_W, no flag

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LIMIT - 1);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  wait_stall;
    logic                  timeout_fire;

    // A WAIT that is still holding counts toward the limit; the edge that
    // would make the count reach WAIT_LIMIT escapes to fetch instead.
    assign wait_stall   = (mode == MODE_WAIT) && !c;
    assign timeout_fire = wait_stall && (wait_cnt == WAIT_LAST);
`else
    logic unused_wait_limit;
    assign unused_wait_limit = ^WAIT_LIMIT;
`endif

    // Next-state mux over the eight ROM modes, plus the decode marker.
    always_comb begin
        next_state = State;
        use_sel    = 1'b0;
        case (mode)
            MODE_DECODE: begin
                next_state = State_Sel;
                use_sel    = 1'b1;
            end
            MODE_FETCH:    next_state = FETCH_VAL;
            MODE_INC:      next_state = inc;
            MODE_JUMP:     next_state = CR;
            MODE_BR_INC:   next_state = c ? CR : inc;
            MODE_BR_DEC: begin
                next_state = c ? CR : State_Sel;
                use_sel    = !c;
            end
            MODE_WAIT:     next_state = c ? inc : State;
            MODE_BR_FETCH: next_state = c ? CR : FETCH_VAL;
        endcase
`ifdef SEQ_WAIT_TIMEOUT_EN
        if (timeout_fire) begin
            next_state = FETCH_VAL;
        end
`endif
    end

    assign Next_State = next_state;

    // State register and registered decode marker; Reset wins over every mode.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            State   <= RESET_VAL;
            Decoded <= 1'b0;
        end else begin
            State   <= next_state;
            Decoded <= use_sel;
        end
    end

`ifdef SEQ_WAIT_TIMEOUT_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            Timeout  <= 1'b0;
        end else if (timeout_fire) begin
            wait_cnt <= '0;
            Timeout  <= 1'b1;
        end else if (wait_stall) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign Timeout = 1'b0;
`endif

endmodule
